// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_ctrl_pkg                                            |
// | Brief   : Shared types for the pipeline hazard/forwarding controller |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package hazard_ctrl_pkg;

   // Operand source selected for an EX-stage ALU input
   typedef enum logic [1:0] {
      FWD_NONE  = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwdmux_sel_t;

   // Controller mode: normal issue, or waiting out a wrong-path fetch
   typedef enum logic [0:0] {
      HZ_RUN   = 1'b0,
      HZ_IKILL = 1'b1
   } hz_state_t;

   // PC and operand-mux part of the control bundle
   typedef struct packed {
      logic        pc_load;
      logic        pc_pending_sel;
      fwdmux_sel_t rs1mux_sel;
      fwdmux_sel_t rs2mux_sel;
   } control_t;

   // Bit positions inside the per-stage load/clear vectors
   localparam int c_IFID  = 0;
   localparam int c_IDEX  = 1;
   localparam int c_EXMEM = 2;
   localparam int c_MEMWB = 3;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_ctrl_if                                             |
// | Brief   : Pipeline status inputs and control outputs of hazard_ctrl  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface hazard_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic             icache_read;
   logic             icache_resp;
   logic             dcache_req;
   logic             dcache_resp;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rs1;
   logic [REG_W-1:0] ex_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_load_regfile;
   logic             ex_is_load;
   logic [REG_W-1:0] mem_rd;
   logic             mem_load_regfile;
   logic [REG_W-1:0] wb_rd;
   logic             wb_load_regfile;
   logic             ex_redirect;
   logic [XLEN-1:0]  ex_redirect_target;

   logic             pc_load;
   logic             pc_pending_sel;
   logic [XLEN-1:0]  pc_pending_target;
   logic             pipe_load_ifid;
   logic             pipe_load_idex;
   logic             pipe_load_exmem;
   logic             pipe_load_memwb;
   logic             pipe_rst_ifid;
   logic             pipe_rst_idex;
   logic             pipe_rst_exmem;
   logic             pipe_rst_memwb;
   logic [1:0]       rs1mux_sel;
   logic [1:0]       rs2mux_sel;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport slave (
      input  icache_read, icache_resp, dcache_req, dcache_resp,
             id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rs1, ex_rs2, ex_rd, ex_load_regfile, ex_is_load,
             mem_rd, mem_load_regfile, wb_rd, wb_load_regfile,
             ex_redirect, ex_redirect_target,
      output pc_load, pc_pending_sel, pc_pending_target,
             pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
             pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
             rs1mux_sel, rs2mux_sel, stall_cnt, flush_cnt
   );

   modport master (
      output icache_read, icache_resp, dcache_req, dcache_resp,
             id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rs1, ex_rs2, ex_rd, ex_load_regfile, ex_is_load,
             mem_rd, mem_load_regfile, wb_rd, wb_load_regfile,
             ex_redirect, ex_redirect_target,
      input  pc_load, pc_pending_sel, pc_pending_target,
             pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
             pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb,
             rs1mux_sel, rs2mux_sel, stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fwd_unit                                                   |
// | Brief   : Forwarding comparator for one EX-stage source operand      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fwd_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] i_ex_rs,
   input  logic [REG_W-1:0] i_mem_rd,
   input  logic             i_mem_we,
   input  logic [REG_W-1:0] i_wb_rd,
   input  logic             i_wb_we,
   output fwdmux_sel_t      o_sel
);

   // Youngest producer wins; x0 is never a forwarding source
   always_comb begin
      o_sel = FWD_NONE;
      if (i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs)) begin
         o_sel = FWD_EXMEM;
      end else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs)) begin
         o_sel = FWD_MEMWB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_ctrl                                                |
// | Brief   : 5-stage pipeline stall/flush/forwarding controller with    |
// |           wrong-path fetch tracking and performance counters        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_W  = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);

   localparam logic [0:0]       c_ST_RUN   = 1'b0;
   localparam logic [0:0]       c_ST_IKILL = 1'b1;
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic [0:0]       r_state;
   logic [0:0]       w_next_state;
   logic [XLEN-1:0]  r_pend_tgt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   fwdmux_sel_t w_rs1_sel;
   fwdmux_sel_t w_rs2_sel;
   control_t    w_ctrl;
   logic [3:0]  w_load;
   logic [3:0]  w_clr;
   logic        w_dstall;
   logic        w_istall;
   logic        w_rawstall;
   logic        w_latch;
   logic        w_flush;
   logic        w_pc_load;

   function automatic logic f_hit(input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] rd,
                                  input logic             we);
      return we && (rd != '0) && (src == rd);
   endfunction

   assign w_dstall = bus.dcache_req  & ~bus.dcache_resp;
   assign w_istall = bus.icache_read & ~bus.icache_resp;

   // With forwarding only a load in EX forces a bubble; without it any
   // pending EX or MEM write does (WB is bypassed inside the regfile).
   generate
      if (FWD_EN != 0) begin : g_fwd
         fwd_unit #(.REG_W(REG_W)) u_fwd_rs1 (
            .i_ex_rs  (bus.ex_rs1),
            .i_mem_rd (bus.mem_rd),
            .i_mem_we (bus.mem_load_regfile),
            .i_wb_rd  (bus.wb_rd),
            .i_wb_we  (bus.wb_load_regfile),
            .o_sel    (w_rs1_sel)
         );
         fwd_unit #(.REG_W(REG_W)) u_fwd_rs2 (
            .i_ex_rs  (bus.ex_rs2),
            .i_mem_rd (bus.mem_rd),
            .i_mem_we (bus.mem_load_regfile),
            .i_wb_rd  (bus.wb_rd),
            .i_wb_we  (bus.wb_load_regfile),
            .o_sel    (w_rs2_sel)
         );
         assign w_rawstall =
            (bus.id_use_rs1 && f_hit(bus.id_rs1, bus.ex_rd, bus.ex_load_regfile & bus.ex_is_load)) ||
            (bus.id_use_rs2 && f_hit(bus.id_rs2, bus.ex_rd, bus.ex_load_regfile & bus.ex_is_load));
      end else begin : g_nofwd
         assign w_rs1_sel  = FWD_NONE;
         assign w_rs2_sel  = FWD_NONE;
         assign w_rawstall =
            (bus.id_use_rs1 && (f_hit(bus.id_rs1, bus.ex_rd,  bus.ex_load_regfile) ||
                                f_hit(bus.id_rs1, bus.mem_rd, bus.mem_load_regfile))) ||
            (bus.id_use_rs2 && (f_hit(bus.id_rs2, bus.ex_rd,  bus.ex_load_regfile) ||
                                f_hit(bus.id_rs2, bus.mem_rd, bus.mem_load_regfile)));
      end
   endgenerate

   // Decide PC load, stage loads and bubbles from mode and hazard priority
   always_comb begin
      w_ctrl.pc_load        = 1'b0;
      w_ctrl.pc_pending_sel = 1'b0;
      w_ctrl.rs1mux_sel     = w_rs1_sel;
      w_ctrl.rs2mux_sel     = w_rs2_sel;
      w_load                = '0;
      w_clr                 = '0;
      w_next_state          = r_state;
      w_latch               = 1'b0;
      w_flush               = 1'b0;
      case (r_state)
         c_ST_IKILL: begin
            // Hold the PC so the outstanding miss address stays stable;
            // whatever it returns is wrong-path and gets squashed.
            w_clr[c_IFID] = 1'b1;
            if (!w_dstall) begin
               w_load[c_IDEX]  = 1'b1;
               w_load[c_EXMEM] = 1'b1;
               w_load[c_MEMWB] = 1'b1;
            end
            if (bus.icache_resp) begin
               w_ctrl.pc_load        = 1'b1;
               w_ctrl.pc_pending_sel = 1'b1;
               w_next_state          = c_ST_RUN;
            end
         end
         default: begin
            // A data-cache miss freezes everything, including a redirect
            if (!w_dstall) begin
               if (bus.ex_redirect) begin
                  w_clr[c_IFID]   = 1'b1;
                  w_clr[c_IDEX]   = 1'b1;
                  w_load[c_EXMEM] = 1'b1;
                  w_load[c_MEMWB] = 1'b1;
                  w_flush         = 1'b1;
                  if (w_istall) begin
                     w_latch      = 1'b1;
                     w_next_state = c_ST_IKILL;
                  end else begin
                     w_ctrl.pc_load = 1'b1;
                  end
               end else if (w_rawstall) begin
                  w_clr[c_IDEX]   = 1'b1;
                  w_load[c_EXMEM] = 1'b1;
                  w_load[c_MEMWB] = 1'b1;
               end else if (w_istall) begin
                  w_clr[c_IFID]   = 1'b1;
                  w_load[c_IDEX]  = 1'b1;
                  w_load[c_EXMEM] = 1'b1;
                  w_load[c_MEMWB] = 1'b1;
               end else begin
                  w_ctrl.pc_load = 1'b1;
                  w_load         = 4'b1111;
               end
            end
         end
      endcase
   end

   assign w_pc_load = w_ctrl.pc_load & ~rst;

   assign bus.pc_load           = w_pc_load;
   assign bus.pc_pending_sel    = w_ctrl.pc_pending_sel & ~rst;
   assign bus.pc_pending_target = r_pend_tgt;
   assign bus.pipe_load_ifid    = w_load[c_IFID]  & ~rst;
   assign bus.pipe_load_idex    = w_load[c_IDEX]  & ~rst;
   assign bus.pipe_load_exmem   = w_load[c_EXMEM] & ~rst;
   assign bus.pipe_load_memwb   = w_load[c_MEMWB] & ~rst;
   assign bus.pipe_rst_ifid     = w_clr[c_IFID]   & ~rst;
   assign bus.pipe_rst_idex     = w_clr[c_IDEX]   & ~rst;
   assign bus.pipe_rst_exmem    = w_clr[c_EXMEM]  & ~rst;
   assign bus.pipe_rst_memwb    = w_clr[c_MEMWB]  & ~rst;
   assign bus.rs1mux_sel        = rst ? FWD_NONE : w_ctrl.rs1mux_sel;
   assign bus.rs2mux_sel        = rst ? FWD_NONE : w_ctrl.rs2mux_sel;
   assign bus.stall_cnt         = r_stall_cnt;
   assign bus.flush_cnt         = r_flush_cnt;

   // Mode register and the redirect target captured on entry to IKILL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_ST_RUN;
         r_pend_tgt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_latch) begin
            r_pend_tgt <= bus.ex_redirect_target;
         end
      end
   end

   // Free-running wrap-around counters of stalled cycles and redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_load) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         end
         if (w_flush) begin
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline-control unit for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It produces the `control` bundle: forwarding mux selects, pipeline-register load enables and pipeline-register bubble/flush strobes. It supersedes the static control bundle with a parametrised unit that supports a forwarding-disabled mode. It also tracks an in-flight wrong-path instruction fetch and keeps stall and flush performance counters.

Parameters:
XLEN, 32, PC/target width
REG_W, 5, register-index width
FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding enabled; 0 = resolve every RAW hazard by stalling
CNT_W, 32, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
icache_read  in  1  IF fetch request active
icache_resp  in  1  fetch data valid this cycle
dcache_req  in  1  MEM-stage read or write active
dcache_resp  in  1  data access complete this cycle
id_rs1, id_rs2  in  REG_W  ID source registers
id_use_rs1, id_use_rs2  in  1  ID instruction reads that source
ex_rs1, ex_rs2  in  REG_W  EX source registers
ex_rd  in  REG_W;  ex_load_regfile  in  1;  ex_is_load  in  1
mem_rd  in  REG_W;  mem_load_regfile  in  1
wb_rd  in  REG_W;  wb_load_regfile  in  1
ex_redirect  in  1  taken branch/jump resolved in EX
ex_redirect_target  in  XLEN  redirect PC
pc_load  out  1  PC register load
pc_pending_sel  out  1  PC mux takes pc_pending_target
pc_pending_target  out  XLEN  latched redirect target
pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb  out  1 each
pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb  out  1 each  synchronous clear (bubble) at next edge
rs1mux_sel, rs2mux_sel  out  2  00 = ID/EX operand, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (async): state = RUN. All loads and clears are 0. Mux selects are 00. pc_pending_sel = 0, pc_pending_target = 0, counters = 0. All outputs are forced to these values while rst is high, including a reset that arrives mid-stall or in IKILL.
- Control outputs are combinational from the current state and inputs. The state register, pending-target register and counters are updated on the clk rising edge.
- No hazard or forwarding match is ever taken on rd = 0.
- Forwarding (FWD_EN = 1), per source independently:
  - ex_rsN matches mem_rd with mem_load_regfile -> 01.
  - Otherwise, ex_rsN matches wb_rd with wb_load_regfile -> 10.
  - Otherwise -> 00. MEM has priority over WB.
  - With FWD_EN = 0, both selects are tied to 00.
- Conditions, evaluated in priority order:
  - dstall = dcache_req & ~dcache_resp.
  - rawstall: FWD_EN = 1 -> an ID source in use matches ex_rd with ex_is_load & ex_load_regfile. FWD_EN = 0 -> an ID source in use matches ex_rd (ex_load_regfile) or mem_rd (mem_load_regfile). WB needs no check because the regfile bypasses writes internally.
  - istall = icache_read & ~icache_resp.
- RUN actions:
  - dstall: all four pipe_load and pc_load = 0. ex_redirect is ignored while EX is frozen; it is still presented after release.
  - ex_redirect & ~istall: pc_load = 1 (normal PC mux carries the target), pipe_rst_ifid = pipe_rst_idex = 1, exmem/memwb load.
  - ex_redirect & istall: latch ex_redirect_target, go to IKILL. Same stage clears as above, but pc_load = 0.
  - rawstall: pc_load = 0, pipe_load_ifid = 0, pipe_rst_idex = 1, exmem/memwb load.
  - istall: pc_load = 0, pipe_rst_ifid = 1, idex/exmem/memwb load.
  - Otherwise: pc_load = 1 and all four loads = 1.
  - pipe_rst_exmem and pipe_rst_memwb are always 0.
- IKILL (wrong-path fetch outstanding; the cache address must stay stable):
  - Each cycle: pipe_rst_ifid = 1, pc_load = 0. idex/exmem/memwb advance unless dstall.
  - On icache_resp: pc_load = 1, pc_pending_sel = 1, fetched data discarded via pipe_rst_ifid, go to RUN.
  - A new ex_redirect in IKILL cannot occur because ID/EX holds bubbles.
- Counters: stall_cnt increments on any cycle with pc_load = 0 outside reset. flush_cnt increments once per accepted redirect. Both wrap modulo 2^CNT_W.

Decomposition:
- Package control_itf gains:
  - fwdmux_sel_t enum (FWD_NONE = 00, FWD_EXMEM = 01, FWD_MEMWB = 10).
  - hz_state_t enum (RUN, IKILL).
  - An updated `control` struct carrying pc_load, pc_pending_sel and the two fwdmux_sel_t fields.
- One sub-module, fwd_unit (per-source forwarding comparator, REG_W-parametrised), instantiated twice.

Test Plan:
- Reset asserted mid-IKILL (pc_pending_target = 0x0000_0040) -> all outputs immediately 0/00, pending target 0, state RUN after deassert.
- EX add x5; MEM writes x5, WB writes x5 -> rs1mux_sel = 01. MEM rd = 0, WB rd = 5 -> 10. Rd = 0 at both -> 00.
- ex_is_load rd = x3, ID uses rs2 = x3 -> exactly one cycle pc_load = 0, pipe_load_ifid = 0, pipe_rst_idex = 1, stall_cnt +1. With FWD_EN = 0 and a non-load x3 in EX -> two stall cycles.
- dcache_req held for 4 cycles, resp on cycle 4 -> all loads 0 for 3 cycles, all 1 on the resp cycle.
- ex_redirect target 0x0000_0100 while the icache miss is outstanding; resp 3 cycles later -> ifid cleared for 3 cycles, then pc_load = 1, pc_pending_sel = 1, pc_pending_target = 0x0000_0100, flush_cnt = 1.
- CNT_W = 4, 17 stall cycles -> stall_cnt = 1 (wrap).
